axi_ram_slave: RTL and testbench

- AXI4 slave memory controller downstream of the cache's AXI master backend. Serves line-fill read bursts and write-through or write-back write bursts.
- Converts each AXI transaction into word accesses on a native single-port synchronous RAM (1-cycle read latency).
- Used as the backing memory in cache simulation and FPGA builds. One transaction is in flight at a time.

---
 rtl/axi_ram_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave that maps read/write bursts onto a single-port
// synchronous RAM (1-cycle read latency). One transaction in flight at a time.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   s_axi_aw*/w*/b*   - AXI4 write address, write data and write response
//   s_axi_ar*/r*      - AXI4 read address and read data
//   mem_en, mem_we    - RAM access enable and per-byte write enables
//   mem_addr          - RAM word address
//   mem_wdata         - RAM write data
//   mem_rdata         - RAM read data, valid the cycle after a read access
//
// State | meaning
// IDLE     | waiting for AW or AR; arbitration between the two
// WR_DATA  | accepting W beats, one RAM write per handshake
// WR_RESP  | presenting B until bready
// RD_ISSUE | RAM read access for the current beat
// RD_WAIT  | capturing RAM read data
// RD_DATA  | presenting R until rready
module axi_ram_slave #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 16,
    parameter int NBYTES     = AXI_DATA_W / 8,
    parameter int BYTE_W     = $clog2(NBYTES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AXI_ID_W-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_wdata,
    input  logic [NBYTES-1:0]     s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [AXI_ID_W-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [AXI_ID_W-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr,
    input  logic [AXI_LEN_W-1:0]  s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [AXI_ID_W-1:0]   s_axi_rid,
    output logic [AXI_DATA_W-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  mem_en,
    output logic [NBYTES-1:0]     mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [AXI_DATA_W-1:0] mem_wdata,
    input  logic [AXI_DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA
    } state_t;

    state_t                  state_q,   state_d;
    logic [AXI_ID_W-1:0]     id_q,      id_d;
    logic [AXI_LEN_W-1:0]    len_q,     len_d;
    logic [AXI_LEN_W-1:0]    cnt_q,     cnt_d;
    logic [1:0]              burst_q,   burst_d;
    logic [MEM_ADDR_W-1:0]   addr_q,    addr_d;
    logic                    err_q,     err_d;
    logic                    last_wr_q, last_wr_d;
    logic [AXI_DATA_W-1:0]   rdata_q,   rdata_d;

    logic                  idle;
    logic                  wr_pri;
    logic                  aw_take;
    logic                  ar_take;
    logic                  w_hs;
    logic                  cnt_done;
    logic [MEM_ADDR_W-1:0] addr_next;

    // Low byte-offset bits of the start address do not affect word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[BYTE_W-1:0], s_axi_araddr[BYTE_W-1:0]};

    assign idle     = (state_q == IDLE);
    // Conflicts alternate; last_wr_q starts at 0 so the first conflict goes to write.
    assign wr_pri   = !last_wr_q;
    assign aw_take  = idle && s_axi_awvalid && (!s_axi_arvalid || wr_pri);
    assign ar_take  = idle && s_axi_arvalid && (!s_axi_awvalid || !wr_pri);
    assign w_hs     = (state_q == WR_DATA) && s_axi_wvalid;
    assign cnt_done = (cnt_q == len_q);
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        addr_d    = addr_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (s_axi_awvalid && s_axi_arvalid)
                    last_wr_d = aw_take;
                if (aw_take) begin
                    id_d    = s_axi_awid;
                    len_d   = s_axi_awlen;
                    burst_d = s_axi_awburst;
                    addr_d  = s_axi_awaddr[BYTE_W +: MEM_ADDR_W];
                    cnt_d   = '0;
                    err_d   = (s_axi_awaddr >> (BYTE_W + MEM_ADDR_W)) != '0;
                    state_d = WR_DATA;
                end else if (ar_take) begin
                    id_d    = s_axi_arid;
                    len_d   = s_axi_arlen;
                    burst_d = s_axi_arburst;
                    addr_d  = s_axi_araddr[BYTE_W +: MEM_ADDR_W];
                    cnt_d   = '0;
                    err_d   = (s_axi_araddr >> (BYTE_W + MEM_ADDR_W)) != '0;
                    state_d = RD_ISSUE;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 1'b1;
                    // wlast must coincide exactly with the beat count reaching len.
                    if (s_axi_wlast != cnt_done)
                        err_d = 1'b1;
                    if (s_axi_wlast || cnt_done)
                        state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready)
                    state_d = IDLE;
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = err_q ? '0 : mem_rdata;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    if (cnt_done) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_next;
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_awready = aw_take;
    assign s_axi_arready = ar_take;
    assign s_axi_wready  = (state_q == WR_DATA);
    assign s_axi_bvalid  = (state_q == WR_RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = (s_axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rvalid  = (state_q == RD_DATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = (s_axi_rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = s_axi_rvalid && cnt_done;

    // Errored writes still consume the beat but leave the RAM untouched.
    assign mem_en    = w_hs || (state_q == RD_ISSUE);
    assign mem_we    = (w_hs && !err_q) ? s_axi_wstrb : '0;
    assign mem_addr  = addr_q;
    assign mem_wdata = s_axi_wdata;

endmodule

// File: tb/tb_axi_ram_slave.sv
module tb_axi_ram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [0:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [0:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid, s_axi_arready;
    logic [0:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [0:65535];

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_data [0:15];
    logic        rd_last [0:15];
    logic [1:0]  rd_resp [0:15];
    logic [0:0]  rd_id   [0:15];
    logic [1:0]  bresp_v;
    logic [0:0]  bid_v;

    always #5 clk = ~clk;

    axi_ram_slave dut (
        .clk(clk), .reset(reset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Single-port RAM, 1-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0)
                mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic aw_phase(input logic [0:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 100);
        check("aw_handshake", {31'b0, s_axi_awready}, 32'h1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_phase(input logic [0:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        int n;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 100);
        check("ar_handshake", {31'b0, s_axi_arready}, 32'h1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // Beat i carries base+i; wlast is raised on beat index last_at.
    task automatic w_phase(input logic [31:0] base, input logic [3:0] strb,
                           input int nbeats, input int last_at);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata = base + i; s_axi_wstrb = strb;
            s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < 100);
            check("w_handshake", {31'b0, s_axi_wready}, 32'h1);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp, output logic [0:0] id);
        int n;
        s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 100);
        check("b_handshake", {31'b0, s_axi_bvalid}, 32'h1);
        resp = s_axi_bresp; id = s_axi_bid;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    // Collect nbeats R beats; with toggle, rready alternates each cycle and
    // rdata must not move while a beat is stalled.
    task automatic r_phase(input int nbeats, input bit toggle);
        int n, beat;
        bit hold_v, done;
        logic [31:0] hold_d;
        beat = 0; n = 0; hold_v = 0; done = 0; hold_d = '0;
        s_axi_rready = 1'b1;
        while (!done && n < 400) begin
            @(negedge clk); n++;
            if (s_axi_rvalid) begin
                if (hold_v) check("rdata_stable", s_axi_rdata, hold_d);
                if (s_axi_rready) begin
                    if (beat < 16) begin
                        rd_data[beat] = s_axi_rdata; rd_last[beat] = s_axi_rlast;
                        rd_resp[beat] = s_axi_rresp; rd_id[beat] = s_axi_rid;
                    end
                    beat++; hold_v = 0;
                    if (s_axi_rlast || beat >= nbeats) done = 1;
                end else begin
                    hold_v = 1; hold_d = s_axi_rdata;
                end
            end
            @(posedge clk); #1;
            if (toggle) s_axi_rready = !s_axi_rready;
        end
        s_axi_rready = 1'b0;
        check("r_beat_count", beat, nbeats);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = 2'b01; s_axi_awvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = 2'b01; s_axi_arvalid = 0;
        s_axi_rready = 0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_awready", {31'b0, s_axi_awready}, 0);
        check("rst_arready", {31'b0, s_axi_arready}, 0);
        check("rst_wready",  {31'b0, s_axi_wready}, 0);
        check("rst_bvalid",  {31'b0, s_axi_bvalid}, 0);
        check("rst_rvalid",  {31'b0, s_axi_rvalid}, 0);
        check("rst_rlast",   {31'b0, s_axi_rlast}, 0);
        check("rst_rdata",   s_axi_rdata, 0);
        check("rst_mem_en",  {31'b0, mem_en}, 0);
        check("rst_mem_we",  {28'b0, mem_we}, 0);
        check("rst_mem_addr", {16'b0, mem_addr}, 0);
        @(posedge clk); #1;

        // Single-beat write to byte 0x40 -> word 0x10
        aw_phase(1'b1, 32'h40, 8'd0, 2'b01);
        w_phase(32'hDEADBEEF, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        check("t1_bresp", {30'b0, bresp_v}, 0);
        check("t1_bid", {31'b0, bid_v}, 1);
        check("t1_ram", ram[16'h10], 32'hDEADBEEF);

        // Preload words 0x40..0x47 with their index via an 8-beat INCR write
        aw_phase(1'b0, 32'h100, 8'd7, 2'b01);
        w_phase(32'h40, 4'hF, 8, 7);
        b_phase(bresp_v, bid_v);
        check("t2_pre_bresp", {30'b0, bresp_v}, 0);
        check("t2_pre_ram47", ram[16'h47], 32'h47);

        // 8-beat read burst
        ar_phase(1'b1, 32'h100, 8'd7, 2'b01);
        r_phase(8, 1'b0);
        check("t2_rid", {31'b0, rd_id[0]}, 1);
        for (int i = 0; i < 8; i++) begin
            check("t2_rdata", rd_data[i], 32'h40 + i);
            check("t2_rlast", {31'b0, rd_last[i]}, (i == 7) ? 1 : 0);
            check("t2_rresp", {30'b0, rd_resp[i]}, 0);
        end

        // Same read with rready toggling
        ar_phase(1'b0, 32'h100, 8'd7, 2'b01);
        r_phase(8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t3_rdata", rd_data[i], 32'h40 + i);
            check("t3_rlast", {31'b0, rd_last[i]}, (i == 7) ? 1 : 0);
        end

        // Partial write strb=0x3 over all-ones
        aw_phase(1'b0, 32'h80, 8'd0, 2'b01);
        w_phase(32'hFFFFFFFF, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        aw_phase(1'b0, 32'h80, 8'd0, 2'b01);
        w_phase(32'h1234ABCD, 4'h3, 1, 0);
        b_phase(bresp_v, bid_v);
        ar_phase(1'b0, 32'h80, 8'd0, 2'b01);
        r_phase(1, 1'b0);
        check("t4_rdata", rd_data[0], 32'hFFFFABCD);
        check("t4_ram", ram[16'h20], 32'hFFFFABCD);

        // Arbitration: preload word 0x101 = 0x33333333
        aw_phase(1'b0, 32'h404, 8'd0, 2'b01);
        w_phase(32'h33333333, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);

        // First conflict: write wins, then the read sees the new data
        s_axi_awid = 1'b0; s_axi_awaddr = 32'h400; s_axi_awlen = 0; s_axi_awburst = 2'b01;
        s_axi_arid = 1'b1; s_axi_araddr = 32'h400; s_axi_arlen = 0; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("c1_awready", {31'b0, s_axi_awready}, 1);
        check("c1_arready", {31'b0, s_axi_arready}, 0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        w_phase(32'h11111111, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        ar_phase(1'b1, 32'h400, 8'd0, 2'b01);
        r_phase(1, 1'b0);
        check("c1_rdata", rd_data[0], 32'h11111111);

        // Second conflict: read wins and returns the old data
        s_axi_awid = 1'b0; s_axi_awaddr = 32'h404; s_axi_awlen = 0; s_axi_awburst = 2'b01;
        s_axi_arid = 1'b0; s_axi_araddr = 32'h404; s_axi_arlen = 0; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("c2_awready", {31'b0, s_axi_awready}, 0);
        check("c2_arready", {31'b0, s_axi_arready}, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        r_phase(1, 1'b0);
        check("c2_rdata", rd_data[0], 32'h33333333);
        aw_phase(1'b0, 32'h404, 8'd0, 2'b01);
        w_phase(32'h22222222, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        check("c2_ram", ram[16'h101], 32'h22222222);

        // Out-of-range read: word 0 holds data but must not be returned
        aw_phase(1'b0, 32'h0, 8'd0, 2'b01);
        w_phase(32'h55, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        ar_phase(1'b0, 32'h80000000, 8'd0, 2'b01);
        r_phase(1, 1'b0);
        check("oor_rresp", {30'b0, rd_resp[0]}, 2);
        check("oor_rdata", rd_data[0], 0);

        // Early wlast on beat 2 of a 4-beat burst
        aw_phase(1'b1, 32'h200, 8'd3, 2'b01);
        w_phase(32'h900, 4'hF, 2, 1);
        b_phase(bresp_v, bid_v);
        check("early_last_bresp", {30'b0, bresp_v}, 2);
        check("early_last_bid", {31'b0, bid_v}, 1);

        // Error flag cleared for the next transaction
        ar_phase(1'b0, 32'h40, 8'd0, 2'b01);
        r_phase(1, 1'b0);
        check("err_clear_rresp", {30'b0, rd_resp[0]}, 0);
        check("err_clear_rdata", rd_data[0], 32'hDEADBEEF);

        // FIXED burst: both beats land on word 0xC0, neighbour untouched
        aw_phase(1'b0, 32'h304, 8'd0, 2'b01);
        w_phase(32'h77, 4'hF, 1, 0);
        b_phase(bresp_v, bid_v);
        aw_phase(1'b0, 32'h300, 8'd1, 2'b00);
        w_phase(32'hA0, 4'hF, 2, 1);
        b_phase(bresp_v, bid_v);
        check("fixed_bresp", {30'b0, bresp_v}, 0);
        check("fixed_ram_c0", ram[16'hC0], 32'hA1);
        check("fixed_ram_c1", ram[16'hC1], 32'h77);

        // Reset mid-burst: no RAM writes afterwards
        aw_phase(1'b0, 32'h500, 8'd3, 2'b01);
        w_phase(32'hB0, 4'hF, 1, 99);
        do_reset();
        s_axi_wdata = 32'hBAD; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_wready", {31'b0, s_axi_wready}, 0);
        check("mid_rst_mem_en", {31'b0, mem_en}, 0);
        check("mid_rst_mem_we", {28'b0, mem_we}, 0);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        check("mid_rst_ram", ram[16'h140], 32'hB0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
